// File: rtl/mult32x32_pkg.sv
// Shared constants and types for the 32x32 fast multiplier datapath.
package mult32x32_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] SHIFT_0   = 2'b00;
  localparam logic [1:0] SHIFT_16A = 2'b01;
  localparam logic [1:0] SHIFT_16B = 2'b10;
  localparam logic [1:0] SHIFT_32  = 2'b11;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [2*WORD_W-1:0] operand_t;
  typedef logic [4*WORD_W-1:0] product_t;

endpackage

// File: rtl/mult32x32_fast_dp_mult16x16.sv
// Combinational unsigned word multiplier feeding the partial-product path.
module mult16x16 #(
  parameter int W = 16
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] p
);

  assign p = {{W{1'b0}}, x} * {{W{1'b0}}, y};

endmodule

// File: rtl/mult32x32_fast_dp.sv
// Datapath for the 32x32 fast multiplier: operand capture, word select,
// shifted partial-product accumulation and result hand-off on busy fall.
module mult32x32_fast_dp
  import mult32x32_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  busy,
  input  logic [2*WORD_W-1:0]   a,
  input  logic [2*WORD_W-1:0]   b,
  input  logic                  a_sel,
  input  logic                  b_sel,
  input  logic [1:0]            shift_sel,
  input  logic                  upd_prod,
  input  logic                  clr_prod,
  output logic                  a_msw_is_0,
  output logic                  b_msw_is_0,
  output logic [4*WORD_W-1:0]   product,
  output logic [4*WORD_W-1:0]   result,
  output logic                  done
);

  localparam int OP_W   = 2 * WORD_W;
  localparam int PROD_W = 4 * WORD_W;

  logic [OP_W-1:0]   a_reg, b_reg;
  logic [WORD_W-1:0] a_word, b_word;
  logic [OP_W-1:0]   pp;
  logic [PROD_W-1:0] shifted;
  logic              busy_d;

  // Operands freeze while the FSM is busy so a stray start cannot corrupt a run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (start && !busy) begin
      a_reg <= a;
      b_reg <= b;
    end
  end

  assign a_msw_is_0 = (a_reg[OP_W-1:WORD_W] == '0);
  assign b_msw_is_0 = (b_reg[OP_W-1:WORD_W] == '0);

  assign a_word = a_sel ? a_reg[OP_W-1:WORD_W] : a_reg[WORD_W-1:0];
  assign b_word = b_sel ? b_reg[OP_W-1:WORD_W] : b_reg[WORD_W-1:0];

  mult16x16 #(.W(WORD_W)) u_mult16x16 (
    .x (a_word),
    .y (b_word),
    .p (pp)
  );

  always_comb begin
    shifted = {{OP_W{1'b0}}, pp};
    case (shift_sel)
      SHIFT_0:   shifted = {{OP_W{1'b0}}, pp};
      SHIFT_16A: shifted = {{OP_W{1'b0}}, pp} << WORD_W;
      SHIFT_16B: shifted = {{OP_W{1'b0}}, pp} << WORD_W;
      SHIFT_32:  shifted = {{OP_W{1'b0}}, pp} << OP_W;
      default:   shifted = {{OP_W{1'b0}}, pp};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      product <= '0;
    end else if (clr_prod) begin
      product <= '0;
    end else if (upd_prod) begin
      product <= product + shifted;
    end
  end

  // Falling edge of busy marks completion; result stays put until the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_d <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      busy_d <= busy;
      done   <= 1'b0;
      if (busy_d && !busy) begin
        result <= product;
        done   <= 1'b1;
      end
    end
  end

endmodule
